config_stream_loader: RTL and testbench

Bit-serializer that sits directly upstream of a config_tile shift chain, such as the one inside the baked switch-box and connection-block tiles. It accepts configuration words from the host or bus side over a valid/ready handshake and shifts exactly CHAIN_LEN bits into the chain, one bit per cycle, with the shift enable asserted. It then issues a single-cycle hard set so the chain latches its configuration, and reports completion.

---
 rtl/config_stream_loader.sv | 115 +++++++++++
 tb/tb_config_stream_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - serializes configuration words into a config_tile shift chain
// Accepts words over valid/ready, shifts CHAIN_LEN bits LSB-first with cen, then pulses cset.
module config_stream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1164,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              cen,
  output logic              cfg_shift,
  output logic              cset,
  output logic              busy,
  output logic              done
);

  localparam int WL_W = $clog2(WORD_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_SET   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WL_W-1:0]   word_left_q, word_left_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              data_ready_q, data_ready_d;
  logic              cen_q, cen_d;
  logic              cfg_shift_q, cfg_shift_d;
  logic              cset_q, cset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    shreg_d     = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bits_left_d = CNT_W'(CHAIN_LEN);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // data_ready_q is high exactly while in S_WAIT, so valid alone completes the handshake
        if (data_valid && data_ready_q) begin
          shreg_d     = data_in;
          word_left_d = (32'(bits_left_q) >= 32'(WORD_W)) ? WL_W'(WORD_W) : WL_W'(bits_left_q);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d     = shreg_q >> 1;
        word_left_d = word_left_q - WL_W'(1);
        bits_left_d = bits_left_q - CNT_W'(1);
        if (word_left_q == WL_W'(1)) begin
          state_d = (bits_left_q == CNT_W'(1)) ? S_SET : S_WAIT;
        end
      end
      S_SET:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    data_ready_d = (state_d == S_WAIT);
    cen_d        = (state_d == S_SHIFT);
    cfg_shift_d  = cen_d & shreg_d[0];
    cset_d       = (state_d == S_SET);
    busy_d       = (state_d == S_WAIT) || (state_d == S_SHIFT) || (state_d == S_SET);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bits_left_q  <= '0;
      word_left_q  <= '0;
      shreg_q      <= '0;
      data_ready_q <= 1'b0;
      cen_q        <= 1'b0;
      cfg_shift_q  <= 1'b0;
      cset_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      word_left_q  <= word_left_d;
      shreg_q      <= shreg_d;
      data_ready_q <= data_ready_d;
      cen_q        <= cen_d;
      cfg_shift_q  <= cfg_shift_d;
      cset_q       <= cset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign cen        = cen_q;
  assign cfg_shift  = cfg_shift_q;
  assign cset       = cset_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - directed bench for config_stream_loader
// Three instances: 4-bit words into 10 and 8 bit chains, and the default 32/1164 configuration.
module tb_config_stream_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;

  logic a_ready, a_cen, a_sh, a_cset, a_busy, a_done;
  logic b_ready, b_cen, b_sh, b_cset, b_busy, b_done;
  logic c_ready, c_cen, c_sh, c_cset, c_busy, c_done;

  always #5 clk = ~clk;

  config_stream_loader #(.WORD_W(4), .CHAIN_LEN(10)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_in[3:0]), .data_valid(data_valid),
    .data_ready(a_ready), .cen(a_cen), .cfg_shift(a_sh), .cset(a_cset), .busy(a_busy), .done(a_done));

  config_stream_loader #(.WORD_W(4), .CHAIN_LEN(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_in[3:0]), .data_valid(data_valid),
    .data_ready(b_ready), .cen(b_cen), .cfg_shift(b_sh), .cset(b_cset), .busy(b_busy), .done(b_done));

  config_stream_loader u_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_in), .data_valid(data_valid),
    .data_ready(c_ready), .cen(c_cen), .cfg_shift(c_sh), .cset(c_cset), .busy(c_busy), .done(c_done));

  int   sel;
  logic o_ready, o_cen, o_sh, o_cset, o_busy, o_done;

  always_comb begin
    case (sel)
      0:       {o_ready, o_cen, o_sh, o_cset, o_busy, o_done} = {a_ready, a_cen, a_sh, a_cset, a_busy, a_done};
      1:       {o_ready, o_cen, o_sh, o_cset, o_busy, o_done} = {b_ready, b_cen, b_sh, b_cset, b_busy, b_done};
      default: {o_ready, o_cen, o_sh, o_cset, o_busy, o_done} = {c_ready, c_cen, c_sh, c_cset, c_busy, c_done};
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0]   words [0:63];
  logic [63:0]   cen_vec, cset_vec, done_vec, ready_vec;
  logic [2047:0] bitbuf;
  int            nbits, n_cset, n_done, n_hs, viol, first_cset, first_done;
  logic [5:0]    post_rst;

  // Runs one load on the selected instance; cycle k=1 is the cycle after start is sampled.
  task automatic run_load(input int s, input int ncyc, input int stall_lo, input int stall_hi,
                          input int spur1, input int spur2, input int rst_at);
    int  w;
    logic hs;
    sel = s;
    w = 0;
    cen_vec = '0; cset_vec = '0; done_vec = '0; ready_vec = '0; bitbuf = '0;
    nbits = 0; n_cset = 0; n_done = 0; n_hs = 0; viol = 0; first_cset = -1; first_done = -1;
    post_rst = '1;
    data_valid = 1'b0;
    case (s)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      if (k == spur1 || k == spur2) begin
        case (s)
          0: start_a = 1'b1;
          1: start_b = 1'b1;
          default: start_c = 1'b1;
        endcase
      end
      rst = (k == rst_at);
      if (k == rst_at + 1 && rst_at > 0)
        post_rst = {o_ready, o_cen, o_sh, o_cset, o_busy, o_done};
      data_valid = !(k >= stall_lo && k <= stall_hi);
      data_in = words[w];
      if (k < 64) begin
        cen_vec[k] = o_cen; cset_vec[k] = o_cset; done_vec[k] = o_done; ready_vec[k] = o_ready;
      end
      if (o_cen) begin
        bitbuf[nbits] = o_sh;
        nbits++;
      end
      if (o_cset) begin
        n_cset++;
        if (first_cset < 0) first_cset = k;
      end
      if (o_done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if ((o_sh && !o_cen) || (o_cen && o_cset)) viol++;
      hs = o_ready && data_valid;
      if (hs) n_hs++;
      @(posedge clk);
      if (hs && w < 63) w++;
    end
    #1;
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    data_valid = 1'b0;
  endtask

  int bit_err;

  initial begin
    sel = 0;
    for (int i = 0; i < 64; i++) words[i] = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs",
        {a_ready, a_cen, a_sh, a_cset, a_busy, a_done, b_ready, b_cen, b_sh, b_cset, b_busy, b_done,
         c_ready, c_cen, c_sh, c_cset, c_busy, c_done}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Small config with spurious starts during SHIFT (k=3) and DONE (k=15)
    words[0] = 32'hA; words[1] = 32'h5; words[2] = 32'hF;
    run_load(0, 40, 0, 0, 3, 15, 0);
    chk("small_cen", cen_vec, 64'h37BC);
    chk("small_cset", cset_vec, 64'h4000);
    chk("small_done", done_vec, 64'h8000);
    chk("small_ready", ready_vec, 64'h842);
    chk("small_bits", bitbuf[63:0], 64'h35A);
    chk("small_nbits", 64'(nbits), 64'd10);
    chk("small_hs", 64'(n_hs), 64'd3);
    chk("small_viol", 64'(viol), 64'd0);

    // Same load with a 5-cycle stall ahead of word 2
    run_load(0, 40, 6, 10, 0, 0, 0);
    chk("stall_cen", cen_vec, 64'h6F03C);
    chk("stall_cset", cset_vec, 64'h80000);
    chk("stall_done", done_vec, 64'h100000);
    chk("stall_ready", ready_vec, 64'h10FC2);
    chk("stall_bits", bitbuf[63:0], 64'h35A);
    chk("stall_hs", 64'(n_hs), 64'd3);

    // Chain length an exact multiple of the word width
    words[0] = 32'h3; words[1] = 32'hC; words[2] = 32'h0;
    run_load(1, 30, 0, 0, 0, 0, 0);
    chk("exact_cen", cen_vec, 64'h7BC);
    chk("exact_cset", cset_vec, 64'h800);
    chk("exact_done", done_vec, 64'h1000);
    chk("exact_bits", bitbuf[63:0], 64'hC3);
    chk("exact_hs", 64'(n_hs), 64'd2);

    // Defaults: reset during the 20th shift cycle, then 50 quiet cycles
    for (int i = 0; i < 64; i++) words[i] = (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i * 7);
    run_load(2, 71, 0, 0, 0, 0, 21);
    chk("rst_outputs", 64'(post_rst), 64'h0);
    chk("rst_no_cset", 64'(n_cset), 64'd0);

    // Fresh full-length load at defaults
    run_load(2, 1210, 0, 0, 0, 0, 0);
    bit_err = 0;
    for (int j = 0; j < 1164; j++)
      if (bitbuf[j] !== words[j / 32][j % 32]) bit_err++;
    chk("full_cset_cycle", 64'(first_cset), 64'd1202);
    chk("full_done_cycle", 64'(first_done), 64'd1203);
    chk("full_nbits", 64'(nbits), 64'd1164);
    chk("full_bit_err", 64'(bit_err), 64'd0);
    chk("full_hs", 64'(n_hs), 64'd37);
    chk("full_one_pulse", {32'(n_cset), 32'(n_done)}, {32'd1, 32'd1});
    chk("full_viol", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
